// File: rtl/cache_line_arbiter_if.sv
// Cache/physical-memory bus bundle for the line arbiter: I-cache read port,
// D-cache read/write-back port and the single burst physical-memory port.
interface cache_line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic [LINE_W-1:0] imem_rdata;
    logic              imem_resp;

    logic              dmem_read;
    logic              dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [LINE_W-1:0] dmem_wdata;
    logic [LINE_W-1:0] dmem_rdata;
    logic              dmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter side.
    modport slave (
        input  imem_read, imem_address,
        output imem_rdata, imem_resp,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Cache and memory side.
    modport master (
        output imem_read, imem_address,
        input  imem_rdata, imem_resp,
        output dmem_read, dmem_write, dmem_address, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_line_arbiter.sv
// Serialises I-cache and D-cache line requests onto one burst memory port,
// splitting each line into BEATS beats and reassembling read lines.
module cache_line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    cache_line_arbiter_if.slave bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFS_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, RESP} state_t;

    state_t                        state;
    logic                          last_d;
    logic                          gnt_d;
    logic [ADDR_W-1:0]             addr;
    logic [CNT_W-1:0]              cnt;
    logic [BEATS-1:0][BEAT_W-1:0]  line;
    logic                          pread, pwrite, iresp, dresp;

    logic              want_i, want_d, pick_d, cnt_last;
    logic [ADDR_W-1:0] req_addr;

    assign want_i   = bus.imem_read;
    assign want_d   = bus.dmem_read | bus.dmem_write;
    // Under contention the cache not served last wins.
    assign pick_d   = want_d & (~want_i | ~last_d);
    assign req_addr = pick_d ? bus.dmem_address : bus.imem_address;
    assign cnt_last = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            gnt_d  <= 1'b0;
            addr   <= '0;
            cnt    <= '0;
            line   <= '0;
            pread  <= 1'b0;
            pwrite <= 1'b0;
            iresp  <= 1'b0;
            dresp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (want_i || want_d) begin
                        addr   <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        gnt_d  <= pick_d;
                        last_d <= pick_d;
                        cnt    <= '0;
                        if (pick_d && bus.dmem_write) begin
                            line   <= bus.dmem_wdata;
                            pwrite <= 1'b1;
                            state  <= D_WRITE;
                        end else begin
                            pread  <= 1'b1;
                            state  <= pick_d ? D_READ : I_READ;
                        end
                    end
                end
                I_READ, D_READ, D_WRITE: begin
                    if (bus.pmem_resp) begin
                        if (state != D_WRITE)
                            line[cnt] <= bus.pmem_rdata;
                        cnt <= cnt + 1'b1;
                        if (cnt_last) begin
                            pread  <= 1'b0;
                            pwrite <= 1'b0;
                            iresp  <= ~gnt_d;
                            dresp  <= gnt_d;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    iresp <= 1'b0;
                    dresp <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read    = pread;
    assign bus.pmem_write   = pwrite;
    assign bus.pmem_address = addr;
    assign bus.pmem_wdata   = line[cnt];
    assign bus.imem_rdata   = line;
    assign bus.dmem_rdata   = line;
    assign bus.imem_resp    = iresp;
    assign bus.dmem_resp    = dresp;
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: a burst memory model on the negedge
// plus cache stimulus with hand-computed lines, addresses and beat orders.
module tb_cache_line_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_line_arbiter_if #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) bus();

    cache_line_arbiter #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [63:0] beats [4];
    logic [63:0] wlog [4];
    logic [31:0] burst_addr;
    int gap = 0, mb = 0, wait_c = 0, burst_on = 0;
    int stab_err = 0, rd_seen = 0, wr_cycles = 0, i_pulses = 0, d_pulses = 0;
    int last_beat_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers beats with an optional gap, logs write beats and
    // flags any address or request change inside a burst.
    always @(negedge clk) begin
        if (!rst) begin
            mb = 0; wait_c = 0; burst_on = 0;
            bus.pmem_resp = 1'b0; bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        end else begin
            if (bus.pmem_read)  rd_seen++;
            if (bus.pmem_write) wr_cycles++;
            if (bus.imem_resp)  i_pulses++;
            if (bus.dmem_resp)  d_pulses++;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            if (bus.pmem_read || bus.pmem_write) begin
                if (burst_on == 0) begin
                    burst_on = 1; burst_addr = bus.pmem_address; wait_c = 0;
                end else if (bus.pmem_address != burst_addr) stab_err++;
                if (mb < 4) begin
                    if (wait_c == 0) begin
                        bus.pmem_resp  = 1'b1;
                        bus.pmem_rdata = beats[mb];
                        wlog[mb] = bus.pmem_wdata;
                        if (mb == 3) last_beat_cyc = cyc;
                        mb++;
                        wait_c = gap;
                    end else wait_c--;
                end
            end else begin
                if (burst_on != 0 && mb < 4) stab_err++;
                burst_on = 0; mb = 0; wait_c = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_beats(input logic [63:0] b0, b1, b2, b3);
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    endtask

    // Waits for a resp pulse, checks who got it, then drops that request.
    task automatic serve(input string tag, input bit exp_d, output int at);
        bit found = 0;
        bit is_d = 0;
        at = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (bus.imem_resp || bus.dmem_resp) begin
                found = 1; is_d = bus.dmem_resp; at = cyc;
            end
        end
        if (!found) chk({tag, "_timeout"}, 0, 1);
        else chk(tag, is_d, exp_d);
        @(posedge clk); #1;
        if (is_d) begin bus.dmem_read = 0; bus.dmem_write = 0; end
        else bus.imem_read = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, rc, ip0, dp0, rd0, wr0, st0;
        logic [255:0] wline;
        bus.imem_read = 0; bus.imem_address = '0;
        bus.dmem_read = 0; bus.dmem_write = 0; bus.dmem_address = '0; bus.dmem_wdata = '0;
        set_beats(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pread", bus.pmem_read, 0);
        chk("rst_pwrite", bus.pmem_write, 0);
        chk("rst_paddr", bus.pmem_address, 0);
        chk("rst_resp", {bus.imem_resp, bus.dmem_resp}, 0);
        chk("rst_rdata", bus.imem_rdata, 0);
        @(negedge clk) rst = 1;

        // I-read alone, back-to-back beats
        set_beats(64'h0, {16{4'h1}}, {16{4'h2}}, {16{4'h3}});
        ip0 = i_pulses; dp0 = d_pulses;
        @(posedge clk); #1;
        bus.imem_read = 1; bus.imem_address = 32'h0000_1234;
        serve("t1_who", 0, at);
        chk("t1_addr", burst_addr, 32'h0000_1220);
        chk("t1_rdata", bus.imem_rdata, {beats[3], beats[2], beats[1], beats[0]});
        chk("t1_resp_after_last", at, last_beat_cyc + 1);
        repeat (2) @(posedge clk);
        chk("t1_ipulses", i_pulses - ip0, 1);
        chk("t1_dpulses", d_pulses - dp0, 0);

        // D-write
        wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        ip0 = i_pulses; dp0 = d_pulses; rd0 = rd_seen; wr0 = wr_cycles;
        @(posedge clk); #1;
        bus.dmem_write = 1; bus.dmem_address = 32'h8000_0047; bus.dmem_wdata = wline;
        rc = cyc;
        serve("t2_who", 1, at);
        chk("t2_addr", burst_addr, 32'h8000_0040);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_beat%0d", k), wlog[k], wline[k*64 +: 64]);
        chk("t2_latency", at - rc, 5);
        repeat (2) @(posedge clk);
        chk("t2_dpulses", d_pulses - dp0, 1);
        chk("t2_ipulses", i_pulses - ip0, 0);
        chk("t2_wr_cycles", wr_cycles - wr0, 4);
        chk("t2_no_read", rd_seen - rd0, 0);

        // Contention right after reset: D first, then I
        @(negedge clk) rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        bus.imem_read = 1; bus.imem_address = 32'h0000_0100;
        bus.dmem_read = 1; bus.dmem_address = 32'h0000_0200;
        serve("c1_first_d", 1, at);
        serve("c1_second_i", 0, at);
        @(posedge clk); #1;
        bus.imem_read = 1; bus.dmem_read = 1;
        serve("c2_first_d", 1, at);
        serve("c2_second_i", 0, at);
        @(posedge clk); #1;
        bus.dmem_read = 1;
        serve("c3_d_alone", 1, at);
        @(posedge clk); #1;
        bus.imem_read = 1; bus.dmem_read = 1;
        serve("c4_first_i", 0, at);
        serve("c4_second_d", 1, at);

        // Gapped beats: two idle cycles between beats
        gap = 2;
        set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h5A5A_0000_FFFF_A5A5, 64'h1357_9BDF_2468_ACE0);
        st0 = stab_err; rd0 = rd_seen;
        @(posedge clk); #1;
        bus.imem_read = 1; bus.imem_address = 32'h0000_5F7C;
        serve("g_who", 0, at);
        chk("g_rdata", bus.imem_rdata, {beats[3], beats[2], beats[1], beats[0]});
        chk("g_addr", burst_addr, 32'h0000_5F60);
        chk("g_stable", stab_err - st0, 0);
        chk("g_resp_after_last", at, last_beat_cyc + 1);
        chk("g_read_cycles", rd_seen - rd0, 10);
        gap = 0;

        // Reset after beat 1 of a D-read
        set_beats({16{4'h7}}, {16{4'h8}}, {16{4'h9}}, {16{4'hE}});
        dp0 = d_pulses;
        @(posedge clk); #1;
        bus.dmem_read = 1; bus.dmem_address = 32'h0000_2000;
        begin
            bit hit = 0;
            for (int k = 0; k < 40 && !hit; k++) begin
                @(posedge clk);
                if (mb >= 2) hit = 1;
            end
            if (!hit) chk("r_wait_beat1", 0, 1);
        end
        #1 rst = 0;
        #1;
        chk("r_outs_zero", {bus.pmem_read, bus.pmem_write, bus.imem_resp, bus.dmem_resp}, 0);
        chk("r_paddr_zero", bus.pmem_address, 0);
        chk("r_pwdata_zero", bus.pmem_wdata, 0);
        chk("r_rdata_zero", bus.dmem_rdata, 0);
        bus.dmem_read = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        set_beats(64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                  64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004);
        @(posedge clk); #1;
        bus.imem_read = 1; bus.imem_address = 32'h0000_3010;
        serve("r_new_who", 0, at);
        chk("r_new_rdata", bus.imem_rdata, {beats[3], beats[2], beats[1], beats[0]});
        chk("r_new_addr", burst_addr, 32'h0000_3000);
        chk("r_aborted_no_resp", d_pulses - dp0, 0);

        // D read+write together acts as a write
        wline = {64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555,
                 64'hCCCC_BBBB_AAAA_9999, 64'h0F0F_EEEE_DDDD_0F0F};
        rd0 = rd_seen; wr0 = wr_cycles;
        @(posedge clk); #1;
        bus.dmem_read = 1; bus.dmem_write = 1;
        bus.dmem_address = 32'h0000_4444; bus.dmem_wdata = wline;
        serve("x_who", 1, at);
        chk("x_addr", burst_addr, 32'h0000_4440);
        for (int k = 0; k < 4; k++) chk($sformatf("x_beat%0d", k), wlog[k], wline[k*64 +: 64]);
        chk("x_no_read", rd_seen - rd0, 0);
        chk("x_wr_cycles", wr_cycles - wr0, 4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
